// File: rtl/program_counter.sv
// Program counter with RUN/HALT control.
// The PC can be reset, loaded from the data bus, incremented, or held.
// A wrap pulse marks an increment from all-ones back to zero.
// Halt freezes the PC until resume.
module program_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             oe,
  input  logic             hlt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] bus_out,
  output logic             wrap,
  output logic             halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;

  // Next-state, next-PC and wrap decode; in RUN the priority is hlt > load > inc > hold.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wrap_nxt  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (hlt) begin
          w_state_nxt = HALT;
        end else if (load) begin
          w_pc_nxt = din;
        end else if (inc) begin
          w_pc_nxt   = r_pc + 1'b1;
          w_wrap_nxt = &r_pc;
        end
      end
      HALT: begin
        // While halted, only resume is honoured, and it does not move the PC.
        if (resume) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State, PC and wrap registers; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Output assignments; the bus is gated by oe and driven only from registered pc.
  always_comb begin
    pc      = r_pc;
    wrap    = r_wrap;
    halted  = (r_state == HALT);
    bus_out = oe ? r_pc : '0;
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter.
// Each step pushes model-predicted results to a scoreboard queue.
// Those results are popped and compared after the clock edge.
module tb_program_counter;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       load;
  logic [7:0] din;
  logic       oe;
  logic       hlt;
  logic       resume;
  logic [7:0] pc;
  logic [7:0] bus_out;
  logic       wrap;
  logic       halted;

  int unsigned errors;
  int unsigned checks;

  typedef struct {
    logic [7:0] pc;
    logic       wrap;
    logic       halted;
  } exp_t;

  exp_t q[$];

  // Reference state, updated from the stimulus only.
  logic [7:0] m_pc;
  logic       m_wrap;
  logic       m_halt;

  program_counter #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .load    (load),
    .din     (din),
    .oe      (oe),
    .hlt     (hlt),
    .resume  (resume),
    .pc      (pc),
    .bus_out (bus_out),
    .wrap    (wrap),
    .halted  (halted)
  );

  // Free-running clock, 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, predict the result, and compare after the edge.
  task automatic step(input string tag, input logic r, input logic i, input logic l,
                      input logic [7:0] d, input logic h, input logic res);
    exp_t e;
    @(negedge clk);
    rst = r; inc = i; load = l; din = d; hlt = h; resume = res;
    if (r) begin
      m_pc = 8'h00; m_wrap = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      m_wrap = 1'b0;
      if (res) m_halt = 1'b0;
    end else if (h) begin
      m_halt = 1'b1; m_wrap = 1'b0;
    end else if (l) begin
      m_pc = d; m_wrap = 1'b0;
    end else if (i) begin
      m_wrap = (m_pc == 8'hFF);
      m_pc   = m_pc + 8'h01;
    end else begin
      m_wrap = 1'b0;
    end
    e.pc = m_pc; e.wrap = m_wrap; e.halted = m_halt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, "_pc"},     32'(pc),     32'(e.pc));
    chk({tag, "_wrap"},   32'(wrap),   32'(e.wrap));
    chk({tag, "_halted"}, 32'(halted), 32'(e.halted));
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; inc = 1'b0; load = 1'b0; din = 8'h00; oe = 1'b0; hlt = 1'b0; resume = 1'b0;
    m_pc = 8'h00; m_wrap = 1'b0; m_halt = 1'b0;

    // Reset, then three increments.
    step("rst",  1, 0, 0, 8'h00, 0, 0);
    chk("rst_pc_const", 32'(pc), 32'h00);
    step("inc1", 0, 1, 0, 8'h00, 0, 0);
    chk("inc1_const", 32'(pc), 32'h01);
    step("inc2", 0, 1, 0, 8'h00, 0, 0);
    step("inc3", 0, 1, 0, 8'h00, 0, 0);
    chk("inc3_const", 32'(pc), 32'h03);

    // Load near the top, then increment through the wrap.
    step("ldFE", 0, 0, 1, 8'hFE, 0, 0);
    step("incFF", 0, 1, 0, 8'h00, 0, 0);
    chk("incFF_wrap_const", 32'(wrap), 32'h0);
    step("inc00", 0, 1, 0, 8'h00, 0, 0);
    chk("wrap_pulse_const", 32'(wrap), 32'h1);
    chk("wrap_pc_const", 32'(pc), 32'h00);
    step("hold", 0, 0, 0, 8'h00, 0, 0);
    chk("wrap_clear_const", 32'(wrap), 32'h0);
    step("ld00", 0, 0, 1, 8'h00, 0, 0);

    // Load has priority over inc.
    step("ld10", 0, 0, 1, 8'h10, 0, 0);
    step("ld40inc", 0, 1, 1, 8'h40, 0, 0);
    chk("loadwins_const", 32'(pc), 32'h40);

    // Halt, ignore controls, then resume.
    step("ld05", 0, 0, 1, 8'h05, 0, 0);
    step("hlt", 0, 1, 0, 8'h00, 1, 0);
    chk("hlt_const", 32'(halted), 32'h1);
    for (int k = 0; k < 4; k++) step("inhalt", 0, 1, 1, 8'h99, 1, 0);
    chk("halt_hold_const", 32'(pc), 32'h05);
    step("resume", 0, 1, 1, 8'h99, 0, 1);
    chk("resume_pc_const", 32'(pc), 32'h05);
    step("inc06", 0, 1, 0, 8'h00, 0, 0);
    chk("inc06_const", 32'(pc), 32'h06);
    step("resRun", 0, 0, 0, 8'h00, 0, 1);

    // Output enable gating, including while halted.
    step("ld33", 0, 0, 1, 8'h33, 0, 0);
    @(negedge clk); oe = 1'b0; #1;
    chk("bus_oe0", 32'(bus_out), 32'h00);
    oe = 1'b1; #1;
    chk("bus_oe1", 32'(bus_out), 32'(m_pc));
    chk("bus_oe1_const", 32'(bus_out), 32'h33);
    oe = 1'b0; #1;
    chk("bus_oe0b", 32'(bus_out), 32'h00);
    step("ld33hold", 0, 0, 0, 8'h00, 0, 0);

    // Reset while halted overrides a simultaneous load.
    step("ld77", 0, 0, 1, 8'h77, 0, 0);
    step("hlt77", 0, 0, 0, 8'h00, 1, 0);
    @(negedge clk); oe = 1'b1; #1;
    chk("bus_halt", 32'(bus_out), 32'h77);
    oe = 1'b0;
    step("rstHalt", 1, 0, 1, 8'hAA, 0, 0);
    chk("rstHalt_const", 32'(pc), 32'h00);
    step("postRst", 0, 1, 0, 8'h00, 0, 0);
    chk("postRst_const", 32'(pc), 32'h01);

    // Reset in the cycle right after a wrap.
    step("ldFF", 0, 0, 1, 8'hFF, 0, 0);
    step("wrap2", 0, 1, 0, 8'h00, 0, 0);
    step("rstWrap", 1, 1, 0, 8'h00, 0, 0);
    step("postRst2", 0, 1, 0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter and bus width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: inc  input  1  count enable; advance PC by 1 this edge.
REQ-005 Port: load  input  1  jump; load PC from din this edge.
REQ-006 Port: din  input  WIDTH  jump target from data bus.
REQ-007 Port: oe  input  1  output enable; place PC on bus_out.
REQ-008 Port: hlt  input  1  halt request.
REQ-009 Port: resume  input  1  leave halt state.
REQ-010 Port: pc  output  WIDTH  registered PC value.
REQ-011 Port: bus_out  output  WIDTH  pc when oe=1, else all zeros (combinational from pc and oe).
REQ-012 Port: wrap  output  1  registered one-cycle pulse; increment wrapped from all-ones to zero.
REQ-013 Port: halted  output  1  registered; 1 while in HALT state.

Function
REQ-014 The block SHALL be a two-state FSM, RUN and HALT, with a WIDTH-bit PC register.
REQ-015 In RUN, per-edge priority SHALL be: hlt > load > inc > hold.
REQ-016 RUN with hlt=1: next state HALT; PC holds regardless of load/inc; halted=1 from the next cycle.
REQ-017 RUN with load=1 (hlt=0): PC <= din next edge; inc ignored that edge.
REQ-018 RUN with inc=1 only: PC <= PC+1 modulo 2^WIDTH.
REQ-019 Increment from all-ones SHALL give zero and assert wrap for exactly the following cycle; wrap SHALL be 0 after any other update, including load of din=0.
REQ-020 RUN with no controls: PC holds, wrap=0.
REQ-021 In HALT, inc, load and hlt SHALL be ignored; PC holds; wrap=0.
REQ-022 HALT with resume=1: next state RUN, PC unchanged; controls that edge are not applied; counting resumes the following edge.
REQ-023 resume in RUN SHALL have no effect.
REQ-024 bus_out SHALL reflect pc in the same cycle oe is high, independent of FSM state.
REQ-025 Load latency: din visible on pc one edge after load sampled; increment latency: one edge.
REQ-026 No combinational path from inc, load, din, hlt or resume to any output.

Reset
REQ-027 rst=1 at a rising edge SHALL set pc=0, wrap=0, halted=0, state RUN, overriding all other inputs.
REQ-028 rst asserted mid-operation (including in HALT or the cycle after wrap) SHALL take effect at that edge with no residual state.
REQ-029 After rst deasserts, the first edge with inc=1 SHALL give pc=1.

Verification
REQ-030 Reset then inc=1 for 3 edges -> pc=0,1,2,3; wrap=0; halted=0.
REQ-031 load=1 din=0xFE, then inc for 2 edges -> pc=0xFE, 0xFF, 0x00; wrap=1 only the cycle pc=0x00.
REQ-032 load=1 and inc=1 same edge with din=0x40, pc=0x10 -> pc=0x40 (load wins).
REQ-033 pc=0x05, hlt=1 with inc=1 -> halted=1, pc=0x05; 4 edges inc=1/load=1 din=0x99 -> pc stays 0x05; resume -> halted=0, pc=0x05; next inc -> 0x06.
REQ-034 pc=0x33, oe toggles 0/1 -> bus_out=0x00/0x33 same cycle, pc unchanged.
REQ-035 In HALT with pc=0x77, rst=1 with load=1 din=0xAA -> pc=0x00, halted=0, wrap=0.
